queen_board_checker: RTL and testbench
======================================

QUEEN_BOARD_CHECKER -- requirements
Module: queen_board_checker

Interface
REQ-001 Parameter: COUNT_W, default 8, width of the valid-board counter.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: user_reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream row byte present on in_bus.
REQ-005 Port: in_bus  input  8  one row of a board; bit c set = queen in column c.
REQ-006 Port: in_ready  output  1  block accepts a row this cycle.
REQ-007 Port: busy  output  1  high in any state other than IDLE.
REQ-008 Port: result_valid  output  1  one-cycle pulse; result fields valid.
REQ-009 Port: result_ok  output  1  board is a legal 8-queen placement.
REQ-010 Port: err_code  output  2  first violation: 0 none, 1 row not one-hot, 2 column clash, 3 diagonal clash.
REQ-011 Port: err_row  output  3  row index of the first violation; 0 when err_code=0.
REQ-012 Port: sol_count  output  COUNT_W  number of boards reported with result_ok=1.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, CHECK, REPORT.
REQ-014 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL be high only in IDLE and LOAD.
REQ-015 IDLE SHALL store an accepted beat as row 0 and move to LOAD.
REQ-016 LOAD SHALL store beats as rows 1..7 in order and move to CHECK on acceptance of row 7.
REQ-017 While in_valid is low in LOAD, the FSM SHALL hold with no timeout.
REQ-018 CHECK SHALL examine one row per cycle, index 0..7, for exactly 8 cycles, independent of errors.
REQ-019 Per row: not one-hot -> code 1; else column already in column mask -> code 2; else diagonal clash -> code 3; else the row's column, d1=row+col and d2=row-col+7 SHALL be added to 8-bit column and two 15-bit diagonal masks.
REQ-020 A non-one-hot row SHALL NOT update any mask.
REQ-021 Only the first violation SHALL be recorded in err_code/err_row; later violations SHALL be ignored.
REQ-022 REPORT SHALL last one cycle: result_valid=1, result_ok=(err_code==0); the FSM then returns to IDLE and clears all masks.
REQ-023 Latency: if row 7 is accepted at edge T, result_valid SHALL be high in the cycle following edge T+9.
REQ-024 result_ok, err_code and err_row SHALL hold their values until the next REPORT.
REQ-025 sol_count SHALL increment in REPORT when result_ok=1 and SHALL saturate at 2^COUNT_W-1.
REQ-026 in_valid during CHECK or REPORT SHALL be ignored and SHALL NOT be buffered.

Reset
REQ-027 While user_reset=0: state IDLE, row store, masks, err_code, err_row and sol_count SHALL be 0; result_valid=0, result_ok=0, busy=0.
REQ-028 A reset asserted mid-LOAD or mid-CHECK SHALL discard the partial board without asserting result_valid.
REQ-029 After reset release, the first accepted beat SHALL be treated as row 0.

Configuration
REQ-030 With macro QUEEN_DIAG_CHECK_EN defined, the diagonal masks and code-3 check SHALL be compiled in.
REQ-031 Without QUEEN_DIAG_CHECK_EN, no diagonal logic SHALL exist, code 3 SHALL never be produced, and latency SHALL be unchanged.

Verification
REQ-032 Rows 01,10,80,20,04,40,02,08 -> result_ok=1, err_code=0, err_row=0, sol_count 0->1, result_valid 9 cycles after the last beat.
REQ-033 Rows 01,10,00,20,04,40,02,08 -> result_ok=0, err_code=1, err_row=2; sol_count unchanged.
REQ-034 All eight rows 01 -> err_code=2, err_row=1.
REQ-035 Rows 01,02,04,08,10,20,40,80 -> with QUEEN_DIAG_CHECK_EN: err_code=3, err_row=1; without it: result_ok=1.
REQ-036 user_reset pulsed low after 4 beats, then a full legal board -> exactly one result_valid pulse, result_ok=1, sol_count=1.
REQ-037 COUNT_W=2 with 5 legal boards -> sol_count reaches 3 and holds at 3.

Source files
------------

// File: rtl/queen_board_checker.sv
// queen_board_checker
//   Collects an 8x8 board one row per beat and checks whether it is a legal
//   8-queen placement. The board is loaded in IDLE/LOAD, then CHECK walks the
//   rows 0..7, one per cycle, and REPORT publishes the verdict.
//
//   The result fields are registered when REPORT ends. The result_valid pulse
//   is therefore seen in the cycle after REPORT, which is nine cycles after
//   row 7 is accepted. result_ok, err_code and err_row hold until the next
//   board is reported.
//
//   Optional feature macro: QUEEN_DIAG_CHECK_EN
//     Defined     : builds the diagonal masks and can report error code 3.
//     Not defined : has no diagonal logic. Timing is the same in both builds.
//
// Parameters
//   COUNT_W       width of the sol_count saturating counter
// Ports
//   clk           system clock, rising edge
//   user_reset    asynchronous reset, active low
//   in_valid      a row byte is present on in_bus
//   in_bus        one board row; bit c set means a queen in column c
//   in_ready      a row is accepted this cycle (IDLE and LOAD only)
//   busy          FSM is not in IDLE
//   result_valid  one-cycle pulse; the result fields are valid
//   result_ok     the board is a legal placement
//   err_code      first violation: 0 none, 1 not one-hot, 2 column, 3 diagonal
//   err_row       row of the first violation (0 when err_code is 0)
//   sol_count     number of legal boards reported, saturating

module queen_board_checker #(
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               user_reset,
   input  logic               in_valid,
   input  logic [7:0]         in_bus,
   output logic               in_ready,
   output logic               busy,
   output logic               result_valid,
   output logic               result_ok,
   output logic [1:0]         err_code,
   output logic [2:0]         err_row,
   output logic [COUNT_W-1:0] sol_count
);

   typedef enum logic [1:0] {StIdle, StLoad, StCheck, StReport} state_e;

   state_e       state_q, state_d;
   logic [2:0]   idx_q, idx_d;
   logic [7:0]   rows_q [8];
   logic [7:0]   col_mask_q, col_mask_d;
   logic [1:0]   err_work_q, err_work_d;
   logic [2:0]   err_row_work_q, err_row_work_d;

   logic               result_valid_q;
   logic               result_ok_q;
   logic [1:0]         err_code_q;
   logic [2:0]         err_row_q;
   logic [COUNT_W-1:0] sol_count_q;

   logic       accept;
   logic [7:0] cur_row;
   logic       one_hot;
   logic [2:0] col_idx;
   logic [1:0] row_code;

`ifdef QUEEN_DIAG_CHECK_EN
   logic [14:0] diag1_mask_q, diag1_mask_d;
   logic [14:0] diag2_mask_q, diag2_mask_d;
   logic [3:0]  d1, d2;
   logic [14:0] d1_bit, d2_bit;
   logic        diag_clash;
`endif

   assign in_ready = (state_q == StIdle) || (state_q == StLoad);
   assign busy     = (state_q != StIdle);
   assign accept   = in_valid && in_ready;

   // Row under test during CHECK.
   assign cur_row = rows_q[idx_q];
   assign one_hot = (cur_row != 8'd0) && ((cur_row & (cur_row - 8'd1)) == 8'd0);

   always_comb begin
      col_idx = 3'd0;
      for (int c = 0; c < 8; c++) begin
         if (cur_row[c]) col_idx = 3'(c);
      end
   end

`ifdef QUEEN_DIAG_CHECK_EN
   // d2 is offset by 7 so that it never goes negative (range 0..14).
   assign d1         = {1'b0, idx_q} + {1'b0, col_idx};
   assign d2         = {1'b0, idx_q} + 4'd7 - {1'b0, col_idx};
   assign d1_bit     = 15'd1 << d1;
   assign d2_bit     = 15'd1 << d2;
   assign diag_clash = |(diag1_mask_q & d1_bit) || |(diag2_mask_q & d2_bit);
`endif

   always_comb begin
      row_code = 2'd0;
      if (!one_hot) begin
         row_code = 2'd1;
      end else if (|(col_mask_q & cur_row)) begin
         row_code = 2'd2;
`ifdef QUEEN_DIAG_CHECK_EN
      end else if (diag_clash) begin
         row_code = 2'd3;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      col_mask_d     = col_mask_q;
      err_work_d     = err_work_q;
      err_row_work_d = err_row_work_q;
`ifdef QUEEN_DIAG_CHECK_EN
      diag1_mask_d   = diag1_mask_q;
      diag2_mask_d   = diag2_mask_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StLoad;
               idx_d   = 3'd1;
            end
         end
         StLoad: begin
            if (accept) begin
               idx_d = idx_q + 3'd1;  // wraps to 0 after row 7, ready for CHECK
               if (idx_q == 3'd7) state_d = StCheck;
            end
         end
         StCheck: begin
            idx_d = idx_q + 3'd1;
            if (row_code == 2'd0) begin
               col_mask_d   = col_mask_q | cur_row;
`ifdef QUEEN_DIAG_CHECK_EN
               diag1_mask_d = diag1_mask_q | d1_bit;
               diag2_mask_d = diag2_mask_q | d2_bit;
`endif
            end else if (err_work_q == 2'd0) begin
               err_work_d     = row_code;
               err_row_work_d = idx_q;
            end
            if (idx_q == 3'd7) state_d = StReport;
         end
         StReport: begin
            state_d        = StIdle;
            col_mask_d     = 8'd0;
            err_work_d     = 2'd0;
            err_row_work_d = 3'd0;
`ifdef QUEEN_DIAG_CHECK_EN
            diag1_mask_d   = 15'd0;
            diag2_mask_d   = 15'd0;
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge user_reset) begin
      if (!user_reset) begin
         state_q        <= StIdle;
         idx_q          <= 3'd0;
         col_mask_q     <= 8'd0;
         err_work_q     <= 2'd0;
         err_row_work_q <= 3'd0;
         for (int r = 0; r < 8; r++) rows_q[r] <= 8'd0;
`ifdef QUEEN_DIAG_CHECK_EN
         diag1_mask_q   <= 15'd0;
         diag2_mask_q   <= 15'd0;
`endif
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         col_mask_q     <= col_mask_d;
         err_work_q     <= err_work_d;
         err_row_work_q <= err_row_work_d;
         if (accept) rows_q[idx_q] <= in_bus;
`ifdef QUEEN_DIAG_CHECK_EN
         diag1_mask_q   <= diag1_mask_d;
         diag2_mask_q   <= diag2_mask_d;
`endif
      end
   end

   // The result is latched as REPORT ends, so it stays stable until the next REPORT.
   always_ff @(posedge clk or negedge user_reset) begin
      if (!user_reset) begin
         result_valid_q <= 1'b0;
         result_ok_q    <= 1'b0;
         err_code_q     <= 2'd0;
         err_row_q      <= 3'd0;
         sol_count_q    <= '0;
      end else begin
         result_valid_q <= (state_q == StReport);
         if (state_q == StReport) begin
            result_ok_q <= (err_work_q == 2'd0);
            err_code_q  <= err_work_q;
            err_row_q   <= err_row_work_q;
            if ((err_work_q == 2'd0) && (sol_count_q != {COUNT_W{1'b1}})) begin
               sol_count_q <= sol_count_q + 1'b1;
            end
         end
      end
   end

   assign result_valid = result_valid_q;
   assign result_ok    = result_ok_q;
   assign err_code     = err_code_q;
   assign err_row      = err_row_q;
   assign sol_count    = sol_count_q;

endmodule

// File: tb/tb_queen_board_checker.sv
// Table-driven bench for queen_board_checker. It drives two instances from
// the same inputs: the default COUNT_W=8 and a COUNT_W=2 copy that is used
// to check that sol_count saturates.

module tb_queen_board_checker;

   logic       clk = 1'b0;
   logic       user_reset;
   logic       in_valid;
   logic [7:0] in_bus;

   logic       in_ready, busy, result_valid, result_ok;
   logic [1:0] err_code;
   logic [2:0] err_row;
   logic [7:0] sol_count;

   logic       in_ready2, busy2, result_valid2, result_ok2;
   logic [1:0] err_code2;
   logic [2:0] err_row2;
   logic [1:0] sol_count2;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_sc8 = 0;
   int exp_sc2 = 0;

   always #5 clk = ~clk;

   queen_board_checker #(.COUNT_W(8)) u_dut (
      .clk          (clk),
      .user_reset   (user_reset),
      .in_valid     (in_valid),
      .in_bus       (in_bus),
      .in_ready     (in_ready),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ok    (result_ok),
      .err_code     (err_code),
      .err_row      (err_row),
      .sol_count    (sol_count)
   );

   queen_board_checker #(.COUNT_W(2)) u_dut2 (
      .clk          (clk),
      .user_reset   (user_reset),
      .in_valid     (in_valid),
      .in_bus       (in_bus),
      .in_ready     (in_ready2),
      .busy         (busy2),
      .result_valid (result_valid2),
      .result_ok    (result_ok2),
      .err_code     (err_code2),
      .err_row      (err_row2),
      .sol_count    (sol_count2)
   );

   // Row 0 is held in the top byte.
   typedef struct {
      string       name;
      logic [63:0] rows;
      int          ok;
      int          code;
      int          erow;
      bit          gap;
      bit          junk;
   } vec_t;

   localparam logic [63:0] Legal  = 64'h01_10_80_20_04_40_02_08;
   localparam logic [63:0] Legal2 = 64'h80_08_01_04_20_02_40_10;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send_beats(input logic [63:0] rows, input int nbeats, input bit gap);
      for (int i = 0; i < nbeats; i++) begin
         int w;
         w = 0;
         if (gap && i == 3) begin
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("load_hold_busy", int'(busy), 1);
         end
         in_valid = 1'b1;
         in_bus   = rows[63 - 8*i -: 8];
         while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
         end
         if (w >= 20) check("ready_timeout", 0, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_board(input vec_t v);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      send_beats(v.rows, 8, v.gap);
      check({v.name, "_ready_low_in_check"}, int'(in_ready), 0);
      while (!seen && n < 20) begin
         // Junk offered during CHECK must not be taken as a new board.
         in_valid = v.junk && (n < 8);
         in_bus   = 8'hFF;
         @(posedge clk);
         #1;
         n++;
         if (result_valid) seen = 1'b1;
      end
      in_valid = 1'b0;
      check({v.name, "_latency"}, n, 9);
      if (v.ok == 1) begin
         exp_sc8++;
         if (exp_sc2 < 3) exp_sc2++;
      end
      check({v.name, "_ok"}, int'(result_ok), v.ok);
      check({v.name, "_code"}, int'(err_code), v.code);
      check({v.name, "_row"}, int'(err_row), v.erow);
      check({v.name, "_sc8"}, int'(sol_count), exp_sc8);
      check({v.name, "_sc2"}, int'(sol_count2), exp_sc2);
      @(posedge clk);
      #1;
      check({v.name, "_pulse_once"}, int'(result_valid), 0);
      check({v.name, "_hold_ok"}, int'(result_ok), v.ok);
      check({v.name, "_hold_code"}, int'(err_code), v.code);
      check({v.name, "_hold_row"}, int'(err_row), v.erow);
   endtask

   vec_t vecs[8];

   initial begin
      int seen_rv;
      vecs[0] = '{"legal",      Legal,                  1, 0, 0, 1'b0, 1'b0};
      vecs[1] = '{"row2_empty", 64'h01_10_00_20_04_40_02_08, 0, 1, 2, 1'b0, 1'b0};
      vecs[2] = '{"all_col0",   64'h01_01_01_01_01_01_01_01, 0, 2, 1, 1'b0, 1'b0};
`ifdef QUEEN_DIAG_CHECK_EN
      vecs[3] = '{"diag",       64'h01_02_04_08_10_20_40_80, 0, 3, 1, 1'b0, 1'b0};
`else
      vecs[3] = '{"diag",       64'h01_02_04_08_10_20_40_80, 1, 0, 0, 1'b0, 1'b0};
`endif
      vecs[4] = '{"row0_twohot", 64'h03_10_80_20_04_40_02_08, 0, 1, 0, 1'b0, 1'b0};
      vecs[5] = '{"legal2_gap", Legal2,                 1, 0, 0, 1'b1, 1'b1};
      vecs[6] = '{"col_row7",   64'h01_10_80_20_04_40_02_01, 0, 2, 7, 1'b0, 1'b1};
      vecs[7] = '{"first_wins", 64'h01_00_01_20_04_40_02_08, 0, 1, 1, 1'b0, 1'b0};

      user_reset = 1'b0;
      in_valid   = 1'b0;
      in_bus     = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_rv", int'(result_valid), 0);
      check("rst_ok", int'(result_ok), 0);
      check("rst_code", int'(err_code), 0);
      check("rst_row", int'(err_row), 0);
      check("rst_sc", int'(sol_count), 0);
      user_reset = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ready", int'(in_ready), 1);

      for (int i = 0; i < 8; i++) run_board(vecs[i]);

      // A reset in the middle of CHECK drops the board without reporting it.
      send_beats(Legal, 8, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      user_reset = 1'b0;
      #1;
      check("midchk_rst_busy", int'(busy), 0);
      check("midchk_rst_sc", int'(sol_count), 0);
      check("midchk_rst_code", int'(err_code), 0);
      @(posedge clk);
      #1;
      user_reset = 1'b1;
      exp_sc8    = 0;
      exp_sc2    = 0;
      seen_rv    = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (result_valid) seen_rv = 1;
      end
      check("midchk_no_result", seen_rv, 0);

      // Partial load, then reset, then a full board: realigned to row 0.
      send_beats(Legal, 4, 1'b0);
      user_reset = 1'b0;
      @(posedge clk);
      #1;
      check("midload_rst_busy", int'(busy), 0);
      user_reset = 1'b1;
      run_board(vecs[0]);
      check("after_rst_sc", int'(sol_count), 1);

      // Four more legal boards: the 2-bit counter stops at 3.
      for (int k = 0; k < 4; k++) run_board(vecs[(k % 2 == 0) ? 5 : 0]);
      check("sat_sc2", int'(sol_count2), 3);
      check("sc8_five", int'(sol_count), 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
